// File: rtl/mem_dma_controller_pkg.sv
// mem_dma_controller_pkg: shared state encoding, config register selects and pointer step
package mem_dma_controller_pkg;
  typedef enum logic [2:0] {IDLE, RD, CAP, WR, FIN} state_t;
  localparam logic [1:0] SEL_SRC = 2'd0;
  localparam logic [1:0] SEL_DST = 2'd1;
  localparam logic [1:0] SEL_LEN = 2'd2;
  localparam logic [1:0] SEL_CTRL = 2'd3;
  localparam int STEP = 4;
endpackage

// File: rtl/mem_dma_controller_bus_mux.sv
// dma_bus_mux: CPU always owns the bus when active, otherwise the DMA request (zero when idle)
module dma_bus_mux #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  input  logic              cpu_memWrite,
  input  logic              cpu_memToReg,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  input  logic              dma_memWrite,
  input  logic              dma_memToReg,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  output logic              bus_memWrite,
  output logic              bus_memToReg
);
  logic cpu_active;
  always_comb begin
    cpu_active = cpu_memWrite | cpu_memToReg;
    bus_addr = cpu_active ? cpu_addr : dma_addr;
    bus_wdata = cpu_active ? cpu_wdata : dma_wdata;
    bus_memWrite = cpu_active ? cpu_memWrite : dma_memWrite;
    bus_memToReg = cpu_active ? cpu_memToReg : dma_memToReg;
  end
endmodule

// File: rtl/mem_dma_controller.sv
// mem_dma_controller: word-copy DMA that steals only bus cycles the CPU leaves idle
module mem_dma_controller
  import mem_dma_controller_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int LEN_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  input  logic              cpu_memWrite,
  input  logic              cpu_memToReg,
  input  logic              cfg_we,
  input  logic [1:0]        cfg_sel,
  input  logic [DATA_W-1:0] cfg_wdata,
  input  logic [DATA_W-1:0] bus_rdata,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  output logic              bus_memWrite,
  output logic              bus_memToReg,
  output logic              busy,
  output logic              done,
  output logic              irq,
  output logic [LEN_W-1:0]  remaining
);
  state_t state;
  logic [ADDR_W-1:0] src_r, dst_r, src_ptr, dst_ptr, dma_addr;
  logic [DATA_W-1:0] buffer, dma_wdata;
  logic [LEN_W-1:0] len_r, count;
  logic cpu_active, start;
  always_comb begin
    cpu_active = cpu_memWrite | cpu_memToReg;
    start = cfg_we && cfg_sel == SEL_CTRL && cfg_wdata[0] && state == IDLE;
    busy = state != IDLE;
    irq = state == FIN;
    remaining = count;
    dma_addr = state == WR ? dst_ptr : state == RD ? src_ptr : '0;
    dma_wdata = state == WR ? buffer : '0;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      done <= 1'b0;
      src_r <= '0;
      dst_r <= '0;
      len_r <= '0;
      src_ptr <= '0;
      dst_ptr <= '0;
      count <= '0;
      buffer <= '0;
    end else begin
      if (cfg_we && state == IDLE) begin
        if (cfg_sel == SEL_SRC) src_r <= cfg_wdata[ADDR_W-1:0];
        if (cfg_sel == SEL_DST) dst_r <= cfg_wdata[ADDR_W-1:0];
        if (cfg_sel == SEL_LEN) len_r <= cfg_wdata[LEN_W-1:0];
      end
      case (state)
        IDLE: if (start) begin
          done <= 1'b0;
          src_ptr <= src_r;
          dst_ptr <= dst_r;
          count <= len_r;
          state <= len_r == '0 ? FIN : RD;
        end
        RD: if (!cpu_active) state <= CAP;
        CAP: begin
          buffer <= bus_rdata;
          state <= WR;
        end
        WR: if (!cpu_active) begin
          src_ptr <= src_ptr + ADDR_W'(STEP);
          dst_ptr <= dst_ptr + ADDR_W'(STEP);
          count <= count - 1'b1;
          state <= count == LEN_W'(1) ? FIN : RD;
        end
        FIN: begin
          done <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
  dma_bus_mux #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_mux (
    .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata),
    .cpu_memWrite(cpu_memWrite),
    .cpu_memToReg(cpu_memToReg),
    .dma_addr(dma_addr),
    .dma_wdata(dma_wdata),
    .dma_memWrite(state == WR),
    .dma_memToReg(state == RD),
    .bus_addr(bus_addr),
    .bus_wdata(bus_wdata),
    .bus_memWrite(bus_memWrite),
    .bus_memToReg(bus_memToReg)
  );
endmodule

// File: tb/tb_mem_dma_controller.sv
// tb_mem_dma_controller: directed and randomized copies checked against a word-level reference model
module tb_mem_dma_controller;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [31:0] cpu_addr = '0, cpu_wdata = '0, cfg_wdata = '0, bus_rdata = '0;
  logic cpu_memWrite = 1'b0, cpu_memToReg = 1'b0, cfg_we = 1'b0;
  logic [1:0] cfg_sel = '0;
  logic [31:0] bus_addr, bus_wdata;
  logic bus_memWrite, bus_memToReg, busy, done, irq;
  logic [15:0] remaining;
  int checks = 0, errors = 0;
  int busy_cycles = 0, irq_cnt = 0, rd_cnt = 0, last_busy = 0;
  logic [63:0] wq[$];
  logic [31:0] mem[logic [31:0]];

  mem_dma_controller dut (
    .clk(clk), .reset(reset), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_memWrite(cpu_memWrite), .cpu_memToReg(cpu_memToReg), .cfg_we(cfg_we),
    .cfg_sel(cfg_sel), .cfg_wdata(cfg_wdata), .bus_rdata(bus_rdata),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_memWrite(bus_memWrite),
    .bus_memToReg(bus_memToReg), .busy(busy), .done(done), .irq(irq), .remaining(remaining)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rd_mem(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : {a[15:0], 16'hC0DE};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) begin
    if (bus_memToReg) bus_rdata <= rd_mem(bus_addr);
    if (bus_memWrite) mem[bus_addr] = bus_wdata;
  end

  // Observe bus ownership and DMA traffic 1ns after each falling edge, once inputs have settled
  always begin
    @(negedge clk);
    #1;
    if (!reset) begin
      if (busy) busy_cycles++;
      if (irq) irq_cnt++;
      if (cpu_memWrite | cpu_memToReg) begin
        if (busy) chk("cpu_owns_bus", {bus_addr, 31'b0, bus_memToReg}, {cpu_addr, 31'b0, cpu_memToReg});
      end else begin
        if (bus_memWrite) wq.push_back({bus_addr, bus_wdata});
        if (bus_memToReg) rd_cnt++;
      end
    end
  end

  task automatic cfg(input logic [1:0] sel, input logic [31:0] data);
    @(negedge clk);
    cfg_we = 1'b1;
    cfg_sel = sel;
    cfg_wdata = data;
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  // mode: 0 no CPU traffic, 1 random CPU reads, 2 three stalls in first RD and two in first WR
  task automatic run(input logic [31:0] src, input logic [31:0] dst, input int len,
                     input int mode, input bit inject, input bit prog, input string tag);
    logic [63:0] exp_q[$];
    int pos, cyc, stalls, srd, swr, b0, i0, w0, r0;
    bit act;
    for (int i = 0; i < len; i++) exp_q.push_back({dst + 32'(4 * i), rd_mem(src + 32'(4 * i))});
    if (prog) begin
      cfg(2'd0, src);
      cfg(2'd1, dst);
      cfg(2'd2, 32'(len));
    end
    b0 = busy_cycles; i0 = irq_cnt; w0 = wq.size(); r0 = rd_cnt;
    @(negedge clk);
    cfg_we = 1'b1; cfg_sel = 2'd3; cfg_wdata = 32'd1;
    @(negedge clk);
    cfg_we = 1'b0;
    chk({tag, "_remaining_start"}, 64'(remaining), 64'(len));
    chk({tag, "_busy_start"}, 64'(busy), 64'd1);
    pos = 0; cyc = 0; stalls = 0; srd = 0; swr = 0;
    while (pos < 3 * len && cyc < 2000) begin
      act = 1'b0;
      if (mode == 1) act = $urandom_range(0, 2) == 0;
      if (mode == 2 && pos == 0 && srd < 3) begin act = 1'b1; srd++; end
      if (mode == 2 && pos == 2 && swr < 2) begin act = 1'b1; swr++; end
      cpu_memToReg = act;
      cpu_addr = 32'h9000 + ($urandom_range(0, 255) << 2);
      cfg_we = inject && (cyc == 1 || cyc == 3);
      cfg_sel = cyc == 1 ? 2'd1 : 2'd3;
      cfg_wdata = cyc == 1 ? 32'h0 : 32'h1;
      if (act && pos % 3 != 1) stalls++;
      else pos++;
      cyc++;
      @(negedge clk);
    end
    cpu_memToReg = 1'b0;
    cfg_we = 1'b0;
    repeat (4) @(negedge clk);
    #2;
    last_busy = busy_cycles - b0;
    chk({tag, "_busy_cycles"}, 64'(last_busy), 64'(3 * len + 1 + stalls));
    chk({tag, "_irq_pulses"}, 64'(irq_cnt - i0), 64'd1);
    chk({tag, "_done"}, 64'(done), 64'd1);
    chk({tag, "_remaining_end"}, 64'(remaining), 64'd0);
    chk({tag, "_busy_end"}, 64'(busy), 64'd0);
    chk({tag, "_reads"}, 64'(rd_cnt - r0), 64'(len));
    chk({tag, "_writes"}, 64'(wq.size() - w0), 64'(len));
    for (int i = 0; i < len && w0 + i < wq.size(); i++) chk({tag, "_write_word"}, wq[w0 + i], exp_q[i]);
  endtask

  initial begin
    int w0, b0, i0, r0;
    bit hit;
    logic [31:0] s, d;
    #1;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_irq", 64'(irq), 64'd0);
    chk("rst_remaining", 64'(remaining), 64'd0);
    chk("rst_bus", {bus_addr, bus_wdata[29:0], bus_memWrite, bus_memToReg}, 64'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    cpu_memWrite = 1'b1; cpu_addr = 32'h10; cpu_wdata = 32'hDEADBEEF;
    #1;
    chk("pass_addr", 64'(bus_addr), 64'h10);
    chk("pass_wdata", 64'(bus_wdata), 64'hDEADBEEF);
    chk("pass_ctrl", {62'b0, bus_memWrite, bus_memToReg}, 64'b10);
    chk("pass_busy", 64'(busy), 64'd0);
    @(negedge clk);
    cpu_memWrite = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    #1;
    chk("idle_bus_zero", {bus_addr, bus_wdata[29:0], bus_memWrite, bus_memToReg}, 64'd0);
    for (int i = 0; i < 4; i++) mem[32'h2B00 + 32'(4 * i)] = 32'hA0 + 32'(i);
    run(32'h2B00, 32'h1800, 4, 0, 1'b0, 1'b1, "uncontended");
    chk("uncontended_13", 64'(last_busy), 64'd13);
    run(32'h2B00, 32'h1900, 2, 2, 1'b0, 1'b1, "contention");
    chk("contention_12", 64'(last_busy), 64'd12);
    run(32'h2B00, 32'h1A00, 0, 0, 1'b0, 1'b1, "zero_len");
    chk("zero_len_1", 64'(last_busy), 64'd1);
    run(32'h2B00, 32'h1B00, 3, 0, 1'b1, 1'b1, "ignored_writes");
    for (int t = 0; t < 6; t++) begin
      s = 32'h4000 + ($urandom_range(0, 63) << 2);
      d = 32'h6000 + ($urandom_range(0, 63) << 2);
      for (int i = 0; i < 8; i++) mem[s + 32'(4 * i)] = $urandom;
      run(s, d, $urandom_range(1, 6), 1, 1'b0, 1'b1, "random");
    end
    cfg(2'd0, 32'h2B00);
    cfg(2'd1, 32'h1C00);
    cfg(2'd2, 32'd8);
    w0 = wq.size();
    @(negedge clk);
    cfg_we = 1'b1; cfg_sel = 2'd3; cfg_wdata = 32'd1;
    @(negedge clk);
    cfg_we = 1'b0;
    hit = 1'b0;
    for (int c = 0; c < 50 && !hit; c++) begin
      @(negedge clk);
      #2;
      hit = wq.size() - w0 == 2;
    end
    chk("rst_mid_reached", 64'(hit), 64'd1);
    @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    chk("rst_mid_busy", 64'(busy), 64'd0);
    chk("rst_mid_done", 64'(done), 64'd0);
    chk("rst_mid_remaining", 64'(remaining), 64'd0);
    chk("rst_mid_bus", {bus_addr, bus_wdata[29:0], bus_memWrite, bus_memToReg}, 64'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    #2;
    chk("rst_mid_no_more_writes", 64'(wq.size() - w0), 64'd2);
    b0 = busy_cycles; i0 = irq_cnt; r0 = rd_cnt;
    run(32'h0, 32'h0, 0, 0, 1'b0, 1'b0, "after_reset");
    chk("after_reset_no_reads", 64'(rd_cnt - r0), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_dma_controller.md
# mem_dma_controller

Word-copy DMA engine and bus arbiter in front of the memory selector's shared address/data bus. The CPU programs source, destination and length through a small configuration port. The block then copies words between any two mapped regions (RAM, instruction memory, video, HD, timer) using idle bus cycles. The CPU always wins the bus; the DMA only steals cycles the CPU leaves unused, so the CPU never stalls.

## Interface

Parameters:
- ADDR_W, 32, bus address width (byte address)
- DATA_W, 32, bus data width
- LEN_W, 16, transfer length counter width (words)

Ports:
- clk  in  1  single system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- cpu_addr  in  ADDR_W  CPU data-port address
- cpu_wdata  in  DATA_W  CPU write data
- cpu_memWrite  in  1  CPU write request
- cpu_memToReg  in  1  CPU read request
- cfg_we  in  1  configuration register write strobe
- cfg_sel  in  2  register select: 0 src, 1 dst, 2 len, 3 ctrl
- cfg_wdata  in  DATA_W  configuration write data
- bus_rdata  in  DATA_W  read data from memory mux, valid one cycle after address
- bus_addr  out  ADDR_W  address to memory selector
- bus_wdata  out  DATA_W  write data to memory selector
- bus_memWrite  out  1  write strobe to memory selector
- bus_memToReg  out  1  read request to memory selector
- busy  out  1  transfer in progress
- done  out  1  sticky completion flag
- irq  out  1  one-cycle completion pulse
- remaining  out  LEN_W  words still to copy

## Operation

- cpu_active = cpu_memWrite | cpu_memToReg. When cpu_active is high, all bus_* outputs are a combinational pass-through of cpu_* regardless of DMA state.
- Config registers src_r, dst_r, len_r are written on cfg_we only while busy=0. Writes while busy are dropped.
- A ctrl write with cfg_wdata[0]=1 while busy=0 is a start:
  - clears done;
  - loads the working pointers from src_r and dst_r, and the counter from len_r[LEN_W-1:0].
- A start while busy=1 is ignored.
- Pointers advance by 4 per word. They wrap modulo 2^ADDR_W with no range check; address decode is the selector's job.
- FSM states:
  - IDLE: busy=0. On start with len≠0, go to RD. On start with len=0, go to FIN without touching the bus.
  - RD: when cpu_active=0, drive bus_addr=src_ptr and bus_memToReg=1, then go to CAP. Otherwise hold in RD.
  - CAP: latch bus_rdata into the data buffer (unconditionally, even if the CPU takes the bus this cycle), then go to WR.
  - WR: when cpu_active=0, drive bus_addr=dst_ptr, bus_wdata=buffer and bus_memWrite=1. In the same cycle: src_ptr+=4, dst_ptr+=4, count-=1. Go to RD if the new count≠0, else FIN. Otherwise hold in WR.
  - FIN: set done=1, pulse irq for one cycle, go to IDLE.
- busy=1 in RD, CAP, WR and FIN.
- remaining reflects the live counter.
- When neither the CPU nor the DMA owns the bus, bus_* outputs are all zero.

## Timing

- Reset (asynchronous) forces:
  - state IDLE;
  - busy=0, done=0, irq=0, remaining=0;
  - src_r, dst_r, len_r, pointers and buffer to 0;
  - DMA bus outputs to 0. CPU pass-through remains combinational.
- Reset mid-transfer aborts immediately. No further bus writes occur, and done stays 0.
- An uncontended word costs 3 cycles (RD, CAP, WR). An uncontended N-word transfer has busy high for 3N+1 cycles; irq is asserted in the cycle after the last write.
- Start with len=0: busy high for exactly 1 cycle (FIN), with irq in that cycle.
- Each CPU-active cycle during RD or WR adds exactly one cycle of latency. CAP is never delayed.
- Simultaneous cfg_we and FIN: the write is dropped because busy=1.

## Structure

- A shared package holds:
  - the state encoding constants (IDLE, RD, CAP, WR, FIN);
  - the cfg_sel codes (SEL_SRC, SEL_DST, SEL_LEN, SEL_CTRL);
  - the pointer step constant (4).
- One sub-module, dma_bus_mux, contains the combinational CPU/DMA/idle output mux. The FSM, counters and registers live in mem_dma_controller.

## Test plan

- **Idle pass-through:** reset, then CPU write addr=0x0010, data=0xDEADBEEF -> bus_addr=0x0010, bus_wdata=0xDEADBEEF, bus_memWrite=1 in the same cycle; busy=0.
- **Uncontended copy:**
  - Stimulus: src=0x2B00 (HD), dst=0x1800 (video), len=4, start; memory model returns 0xA0+index.
  - Response: writes 0xA0..0xA3 to 0x1800, 0x1804, 0x1808, 0x180C; busy high 13 cycles; irq is a single pulse; done=1; remaining=0.
- **Contention:**
  - Stimulus: same 2-word copy with cpu_memToReg held high for 3 cycles during the first RD and for 2 cycles during the first WR.
  - Response: completion delayed exactly 5 cycles; data is correct; the CPU address appears on the bus in every contended cycle.
- **Zero length:** len=0, start -> no bus_memWrite or bus_memToReg from the DMA; busy=1 for 1 cycle; irq=1; done=1.
- **Ignored writes:** during a transfer, write dst=0x0000 and start again -> transfer finishes at the original destination; no restart; done set once.
- **Reset mid-transfer:** assert reset after the second write of a len=8 transfer -> all outputs 0 immediately; no further DMA bus cycles; a new start after release runs normally from the reset register values (src=dst=len=0, so immediate FIN).
